// File: rtl/tcrc_serializer_if.sv
// tcrc_serializer_if
//   Bundles the control, data and status signals of the CAN CRC-15
//   accumulator/serializer. The frame controller drives the "master" side;
//   the CRC block is the "slave" side.
//
//   Controller -> CRC block:
//     start        clear CRC and begin accumulating a frame
//     bit_en       one-cycle strobe per non-stuff bit time
//     data_in      transmitted bit, sampled when bit_en=1
//     preload      load crc_reg from preload_val
//     preload_val  15-bit preload value
//     crc_send     stop accumulating, begin serializing the CRC
//     abort        terminate any operation, return to IDLE
//   CRC block -> controller:
//     crc_reg      current CRC register contents
//     crc_bit      serialized CRC bit (crc_reg[14] while shifting, else 0)
//     busy         accumulating or shifting
//     shift_done   one-cycle pulse after the 15th CRC bit
interface tcrc_serializer_if;
  logic        start;
  logic        bit_en;
  logic        data_in;
  logic        preload;
  logic [14:0] preload_val;
  logic        crc_send;
  logic        abort;
  logic [14:0] crc_reg;
  logic        crc_bit;
  logic        busy;
  logic        shift_done;

  modport master (
    output start, bit_en, data_in, preload, preload_val, crc_send, abort,
    input  crc_reg, crc_bit, busy, shift_done
  );

  modport slave (
    input  start, bit_en, data_in, preload, preload_val, crc_send, abort,
    output crc_reg, crc_bit, busy, shift_done
  );
endinterface

// File: rtl/tcrc_serializer.sv
// tcrc_serializer
//   CAN CRC-15 accumulator and serializer. In CALC each bit_en strobe folds
//   data_in into the CRC (stuff bits carry no strobe and are excluded). On
//   crc_send the 15 CRC bits are shifted out MSB-first on crc_bit, one per
//   bit_en strobe, followed by a one-cycle shift_done pulse.
//
//   Ports:
//     clock   rising-edge clock
//     reset   asynchronous active-low reset
//     bus     tcrc_serializer_if.slave (control inputs, CRC/status outputs)
//   Parameter:
//     POLY    generator polynomial, x^15 term implied (CAN: 15'h4599)
module tcrc_serializer #(
  parameter logic [14:0] POLY = 15'h4599
) (
  input  logic               clock,
  input  logic               reset,
  tcrc_serializer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] crc_q,   crc_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        done_q,  done_d;
  logic        nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      crc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Feedback bit of the LFSR-style CRC update.
  assign nxt = bus.data_in ^ crc_q[14];

  // Inputs are decoded as a strict priority chain:
  // abort > start > preload > crc_send > bit_en.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (bus.abort) begin
      state_d = IDLE;
      crc_d   = '0;
      cnt_d   = '0;
    end else if (bus.start) begin
      state_d = CALC;
      crc_d   = '0;
      cnt_d   = '0;
    end else if (bus.preload && (state_q != SHIFT)) begin
      // Preload in SHIFT falls through so the shift continues undisturbed.
      crc_d = bus.preload_val;
    end else if (bus.crc_send && (state_q == CALC)) begin
      state_d = SHIFT;
      cnt_d   = '0;
    end else if (bus.bit_en) begin
      unique case (state_q)
        CALC: begin
          crc_d = {crc_q[13:0], 1'b0} ^ (nxt ? POLY : 15'd0);
        end
        SHIFT: begin
          crc_d = {crc_q[13:0], 1'b0};
          if (cnt_q == 4'd14) begin
            // Terminal strobe: the counter returns to 0 since it is held
            // at 0 whenever the block is not shifting.
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.crc_reg    = crc_q;
  assign bus.crc_bit    = (state_q == SHIFT) ? crc_q[14] : 1'b0;
  assign bus.busy       = (state_q != IDLE);
  assign bus.shift_done = done_q;

endmodule
